// File: rtl/tmr_cnt_ctrl.sv
// Sequencing controller for the timer counter: prescaler/external tick generation,
// load/run/idle sequencing and the count register. Optional one-shot stop: TMR_ONESHOT_EN.
module tmr_cnt_ctrl #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic [WIDTH-1:0] tdr,
  input  logic             load,
  input  logic             en,
  input  logic             ud,
  input  logic [2:0]       cks,
  input  logic             clk_in,
  input  logic             one_shot,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] last_cnt,
  output logic             load_ack,
  output logic             running
);

`ifdef TMR_ONESHOT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PSC_W-1:0] r_psc;
  logic             r_src_d;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_last_cnt;
  logic             r_load_ack;
  logic             r_running;

  logic             w_src;
  logic             w_tick;
  logic             w_wrap;
  logic [WIDTH-1:0] w_cnt_step;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_last_nxt;

`ifndef TMR_ONESHOT_EN
  // Mode select has no effect when the stop state is compiled out.
  logic w_unused_one_shot;
  assign w_unused_one_shot = one_shot;
`endif

  // Tick source: prescaler tap for the low selects, synchronised external clock otherwise.
  always_comb begin
    if (cks[2] == 1'b0) begin
      w_src = r_psc[cks[1:0]];
    end else begin
      w_src = clk_in;
    end
  end

  assign w_tick     = w_src & ~r_src_d;
  assign w_cnt_step = ud ? (r_cnt - {{(WIDTH-1){1'b0}}, 1'b1})
                         : (r_cnt + {{(WIDTH-1){1'b0}}, 1'b1});
  assign w_wrap     = ud ? (r_cnt == {WIDTH{1'b0}}) : (r_cnt == {WIDTH{1'b1}});

  // Free-running prescaler and source edge history; only reset clears them.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_psc   <= {PSC_W{1'b0}};
      r_src_d <= 1'b0;
    end else begin
      r_psc   <= r_psc + {{(PSC_W-1){1'b0}}, 1'b1};
      r_src_d <= w_src;
    end
  end

  // Next state and datapath; last_cnt follows cnt each cycle so a wrap pair lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_cnt;
    if (load) begin
      w_state_nxt = ST_LOAD;
      w_cnt_nxt   = tdr;
      w_last_nxt  = tdr;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (en) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!en) begin
            w_state_nxt = ST_IDLE;
          end else if (w_tick) begin
            w_cnt_nxt = w_cnt_step;
`ifdef TMR_ONESHOT_EN
            if (one_shot && w_wrap) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_state_nxt = ST_RUN;
            end
`else
            w_state_nxt = ST_RUN;
`endif
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
`ifdef TMR_ONESHOT_EN
        ST_STOP: begin
          if (!en) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_STOP;
          end
        end
`endif
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

`ifndef TMR_ONESHOT_EN
  // Wrap detection only steers the one-shot stop.
  logic w_unused_wrap;
  assign w_unused_wrap = w_wrap;
`endif

  // State, count and registered status outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= {WIDTH{1'b0}};
      r_last_cnt <= {WIDTH{1'b0}};
      r_load_ack <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last_cnt <= w_last_nxt;
      r_load_ack <= (w_state_nxt == ST_LOAD);
      r_running  <= (w_state_nxt == ST_RUN);
    end
  end

  assign cnt      = r_cnt;
  assign last_cnt = r_last_cnt;
  assign load_ack = r_load_ack;
  assign running  = r_running;

endmodule

// File: tb/tb_tmr_cnt_ctrl.sv
// Directed self-checking bench for tmr_cnt_ctrl (default build; one-shot section
// runs when TMR_ONESHOT_EN is defined).
module tb_tmr_cnt_ctrl;
  logic       pclk;
  logic       presetn;
  logic [7:0] tdr;
  logic       load;
  logic       en;
  logic       ud;
  logic [2:0] cks;
  logic       clk_in;
  logic       one_shot;
  logic [7:0] cnt;
  logic [7:0] last_cnt;
  logic       load_ack;
  logic       running;

  int total = 0;
  int bad   = 0;

  tmr_cnt_ctrl #(.WIDTH(8), .PSC_W(4)) dut (
    .pclk(pclk), .presetn(presetn), .tdr(tdr), .load(load), .en(en), .ud(ud),
    .cks(cks), .clk_in(clk_in), .one_shot(one_shot), .cnt(cnt), .last_cnt(last_cnt),
    .load_ack(load_ack), .running(running)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_change(input string tag, input logic [7:0] old, input int lim);
    int n = 0;
    while (cnt === old && n < lim) begin
      step();
      n++;
    end
    chk(tag, 32'(cnt !== old), 32'd1);
  endtask

  initial begin
    presetn = 1'b0; tdr = 8'h00; load = 1'b0; en = 1'b0; ud = 1'b0;
    cks = 3'd0; clk_in = 1'b0; one_shot = 1'b0;
    #12;
    chk("rst_cnt", cnt, 8'h00);
    chk("rst_last", last_cnt, 8'h00);
    chk("rst_ack", load_ack, 1'b0);
    chk("rst_run", running, 1'b0);
    step();
    presetn = 1'b1;
    step();

    // load 0xFD then count up at pclk/2
    tdr = 8'hFD; ud = 1'b0; cks = 3'd0; one_shot = 1'b1; load = 1'b1;
    step();
    chk("ld_ack", load_ack, 1'b1);
    chk("ld_cnt", cnt, 8'hFD);
    chk("ld_last", last_cnt, 8'hFD);
    chk("ld_run", running, 1'b0);
    load = 1'b0; en = 1'b1;
    step();
    chk("ld_ack_drop", load_ack, 1'b0);
    chk("run_entry", running, 1'b1);
    chk("run_entry_cnt", cnt, 8'hFD);
    wait_change("up_wait", 8'hFD, 4);
    chk("up_fe", {last_cnt, cnt}, 16'hFDFE);
    step(); chk("up_fe_st", {last_cnt, cnt}, 16'hFEFE);
    step(); chk("up_ff", {last_cnt, cnt}, 16'hFEFF);
    step(); chk("up_ff_st", {last_cnt, cnt}, 16'hFFFF);
    step(); chk("up_wrap", {last_cnt, cnt}, 16'hFF00);
`ifdef TMR_ONESHOT_EN
    chk("os_stop", running, 1'b0);
    begin
      int held = 1;
      for (int i = 0; i < 50; i++) begin
        step();
        if (cnt !== 8'h00 || last_cnt !== 8'h00 || running !== 1'b0) held = 0;
      end
      chk("os_hold50", held, 1);
    end
    en = 1'b0;
    step(); chk("os_idle_run", running, 1'b0);
    en = 1'b1;
    step(); chk("os_idle_to_run", running, 1'b1);
`else
    step(); chk("up_wrap_once", {last_cnt, cnt}, 16'h0000);
    step(); chk("freerun", {last_cnt, cnt}, 16'h0001);
    chk("freerun_run", running, 1'b1);
`endif

    // down underflow at pclk/4
    one_shot = 1'b0; tdr = 8'h01; ud = 1'b1; cks = 3'd1; en = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("dn_start", cnt, 8'h01);
    wait_change("dn_wait", 8'h01, 8);
    chk("dn_00", {last_cnt, cnt}, 16'h0100);
    step(); step(); step();
    chk("dn_00_st", {last_cnt, cnt}, 16'h0000);
    step(); chk("dn_wrap", {last_cnt, cnt}, 16'h00FF);
    step(); chk("dn_wrap_once", {last_cnt, cnt}, 16'hFFFF);

    // external clock: 10 rising edges, 5 high / 7 low
    tdr = 8'h10; ud = 1'b0; cks = 3'd4; clk_in = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("ext_start", cnt, 8'h10);
    for (int i = 0; i < 10; i++) begin
      clk_in = 1'b1;
      repeat (5) step();
      chk("ext_rise", cnt, 8'(8'h11 + i));
      clk_in = 1'b0;
      repeat (7) step();
      chk("ext_fall", cnt, 8'(8'h11 + i));
    end

    // load beats tick: two load cycles at pclk/2 always cover a tick
    cks = 3'd0; tdr = 8'h80; load = 1'b1;
    step(); chk("pri_ld1", cnt, 8'h80); chk("pri_ack", load_ack, 1'b1);
    step(); chk("pri_ld2", {last_cnt, cnt}, 16'h8080);
    load = 1'b0;
    step();
    chk("pri_run", running, 1'b1);
    chk("pri_ack_drop", load_ack, 1'b0);
    chk("pri_cnt", cnt, 8'h80);
    wait_change("pri_wait", 8'h80, 4);
    chk("pri_inc", cnt, 8'h81);

    // en dropped exactly on the next tick edge
    step();
    en = 1'b0;
    step();
    chk("endrop_cnt", cnt, 8'h81);
    chk("endrop_run", running, 1'b0);
    step(); chk("endrop_hold", {last_cnt, cnt}, 16'h8181);

    // asynchronous reset mid-count
    tdr = 8'h37; en = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("arst_pre", cnt, 8'h37);
    chk("arst_pre_run", running, 1'b1);
    #3 presetn = 1'b0;
    #1;
    chk("arst_cnt", cnt, 8'h00);
    chk("arst_last", last_cnt, 8'h00);
    chk("arst_run", running, 1'b0);
    chk("arst_ack", load_ack, 1'b0);
    #10 presetn = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tmr_cnt_ctrl.md
Name: tmr_cnt_ctrl

Overview:
Sequencing controller for the 8-bit timer counter. It owns the count register. It generates the count tick from a pclk prescaler or an external clock, and it applies load, start/stop and up/down control from the timer control register. It drives cnt/last_cnt into the overflow/underflow flag logic, and it guarantees that a wrap is visible there for exactly one pclk cycle.

Parameters:
WIDTH, 8, counter width in bits
PSC_W, 4, prescaler width; selectable taps are pclk/2 .. pclk/16

Ports:
pclk  input  1  APB/system clock
presetn  input  1  reset, asynchronous, active-low
tdr  input  WIDTH  reload value from the timer data register
load  input  1  level load request; while high, counter is (re)loaded every cycle
en  input  1  count enable from control register
ud  input  1  direction: 0 = up, 1 = down
cks  input  3  clock select: 0..3 = pclk/2,/4,/8,/16; 4..7 = external clock
clk_in  input  1  external count clock, already synchronised to pclk
one_shot  input  1  one-shot mode select (used only under TMR_ONESHOT_EN)
cnt  output  WIDTH  current count value
last_cnt  output  WIDTH  count value before the most recent tick
load_ack  output  1  high for each cycle spent in LOAD
running  output  1  high while state == RUN

Behaviour:
- Reset values:
  - cnt = 0, last_cnt = 0, load_ack = 0, running = 0.
  - State IDLE; prescaler = 0; clock-edge history register = 0.
- Prescaler: free-running PSC_W-bit up counter. Increments every pclk and wraps 15 -> 0. It is never cleared except by reset.
- Source select:
  - For cks < 4: src = psc[cks].
  - For cks >= 4: src = clk_in.
  - src_d is src registered on pclk.
  - tick = src & ~src_d (combinational, 1 pclk wide).
  - pclk/2 gives a tick every 2 cycles; pclk/16 every 16.
- Changing cks mid-run may produce one spurious or missing tick. No glitch protection is required.
- State machine, states IDLE, LOAD, RUN, STOP (STOP only under the macro).
- Priority at every edge: load > en deassert > tick.
- Any state, load = 1:
  - Next state LOAD; cnt <= tdr, last_cnt <= tdr.
  - A tick in the same cycle is discarded.
- LOAD:
  - load_ack = 1.
  - Stays in LOAD while load = 1.
  - Otherwise: en = 1 -> RUN, en = 0 -> IDLE.
  - Ticks during LOAD are ignored.
- IDLE: cnt holds; last_cnt <= cnt. en = 1 -> RUN. Ticks ignored.
- RUN:
  - en = 0 -> IDLE; no count on that edge.
  - tick = 1: last_cnt <= cnt; cnt <= cnt + 1 (ud = 0) or cnt - 1 (ud = 1), modulo 2^WIDTH (FF -> 00 up, 00 -> FF down).
  - tick = 0: last_cnt <= cnt.
- Wrap visibility: the (last_cnt, cnt) wrap pair (FF,00) or (00,FF) exists for exactly one pclk cycle after the wrapping tick. last_cnt == cnt in every other steady cycle, so downstream sticky flags are set once.
- ud may change at any time and takes effect at the next tick.
- First tick after entering RUN may arrive anywhere from 1 to 2^(cks+1) cycles later. No prescaler realignment.
- presetn low mid-operation: immediate return to reset values, independent of pclk.

Optional Feature:
Macro TMR_ONESHOT_EN.
- Defined, with one_shot = 1: a tick in RUN that wraps the counter moves to STOP.
  - In STOP, cnt holds the wrapped value; last_cnt <= cnt from the next cycle; running = 0.
  - STOP -> LOAD on load; STOP -> IDLE on en = 0.
  - STOP ignores ticks and en remaining high.
- Defined, with one_shot = 0: identical to the undefined build.
- Undefined: one_shot is ignored, STOP is unreachable, and the counter free-runs through wraps.

Test Plan:
- Reset: presetn low mid-count at cnt = 0x37 -> cnt = 0, last_cnt = 0, running = 0, load_ack = 0 asynchronously.
- Load then count up:
  - Stimulus: tdr = 0xFD, load pulse 1 cycle, then en = 1, ud = 0, cks = 0.
  - Response: load_ack high 1 cycle; cnt = FD, FE, FF, 00 at 2-cycle spacing.
  - Pair (FF,00) is present exactly one cycle, then last_cnt = cnt = 00.
- Down underflow: tdr = 0x01, en = 1, ud = 1, cks = 1 -> cnt 01 -> 00 -> FF, 4 cycles apart; (00,FF) visible one cycle.
- External clock:
  - Stimulus: cks = 4, clk_in toggled with 5-cycle high / 7-cycle low periods, 10 rising edges.
  - Response: cnt advances by exactly 10, one increment per rising edge, none on falling edges.
- Priority:
  - load and tick in the same cycle during RUN, tdr = 0x80 -> cnt = 0x80 (no increment); back to RUN after load drops.
  - en dropped on a tick cycle -> cnt unchanged, state IDLE.
- One-shot (TMR_ONESHOT_EN, one_shot = 1):
  - Stimulus: tdr = 0xFE, up count.
  - Response: cnt = FF, then 00 and STOP; cnt holds 00 for 50 cycles; running = 0; en = 0 -> IDLE.
